// File: rtl/demux_scheduler_if.sv
// Handshake bundle between an upstream bit source / downstream destinations
// and the round-robin demux scheduler.
interface demux_scheduler_if;
  logic       in_valid;
  logic       in_data;
  logic       in_ready;
  logic [7:0] en_mask;
  logic [7:0] out_ack;
  logic [2:0] s;
  logic [7:0] out;
  logic [7:0] out_valid;
  logic       drop;
  logic [7:0] drop_cnt;

  // Environment side: offers bits, enables and acknowledges destinations.
  modport master (
    output in_valid, in_data, en_mask, out_ack,
    input  in_ready, s, out, out_valid, drop, drop_cnt
  );

  // Scheduler side.
  modport slave (
    input  in_valid, in_data, en_mask, out_ack,
    output in_ready, s, out, out_valid, drop, drop_cnt
  );
endinterface

// File: rtl/demux_scheduler.sv
// Round-robin 1-to-8 bit demultiplexer with per-transfer ack timeout.
// A bit is accepted in IDLE, routed to the next enabled destination after
// the last served one, and held in SEND until that destination acks it or
// the wait budget runs out (counted as a drop).
module demux_scheduler #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst_n,
  demux_scheduler_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Wait counter value on the last SEND cycle before a timeout.
  localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] s;
  logic       data_bit;
  logic [3:0] wait_cnt;
  logic [7:0] out;
  logic [7:0] out_valid;
  logic       drop;
  logic [7:0] drop_cnt;
  logic [2:0] candidate;
  logic       ready;
  logic       ack_hit;

  // First enabled index searching base, base+1, ... base+7 (mod 8).
  // Iterating from the far end lets the nearest match overwrite the rest.
  function automatic logic [2:0] pick_next(input logic [7:0] mask,
                                           input logic [2:0] base);
    logic [2:0] idx;
    pick_next = base;
    for (int i = 7; i >= 0; i--) begin
      idx = base + 3'(i);
      if (mask[idx]) begin
        pick_next = idx;
      end
    end
  endfunction

  // Position decode for the select value.
  function automatic logic [7:0] one_hot(input logic [2:0] idx);
    one_hot = 8'h01 << idx;
  endfunction

  // Grant candidate, acceptance condition and ack of the granted destination.
  always_comb begin
    candidate = pick_next(bus.en_mask, ptr);
    ready     = (state == IDLE) && (bus.en_mask != 8'h00);
    ack_hit   = bus.out_ack[s];
  end

  // Scheduler FSM with registered demux outputs, drop pulse and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      s         <= 3'd0;
      data_bit  <= 1'b0;
      wait_cnt  <= 4'd0;
      out       <= 8'h00;
      out_valid <= 8'h00;
      drop      <= 1'b0;
      drop_cnt  <= 8'h00;
    end else begin
      drop <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid && ready) begin
            state     <= SEND;
            s         <= candidate;
            data_bit  <= bus.in_data;
            wait_cnt  <= 4'd0;
            out_valid <= one_hot(candidate);
            out       <= bus.in_data ? one_hot(candidate) : 8'h00;
          end else begin
            out_valid <= 8'h00;
            out       <= 8'h00;
          end
        end
        SEND: begin
          if (ack_hit) begin
            // Ack wins even on the timeout boundary cycle.
            state     <= IDLE;
            ptr       <= s + 3'd1;
            out_valid <= 8'h00;
            out       <= 8'h00;
          end else if (wait_cnt == LAST_WAIT) begin
            state     <= IDLE;
            ptr       <= s + 3'd1;
            out_valid <= 8'h00;
            out       <= 8'h00;
            drop      <= 1'b1;
            if (drop_cnt != 8'hFF) begin
              drop_cnt <= drop_cnt + 8'd1;
            end else begin
              drop_cnt <= drop_cnt;
            end
          end else begin
            wait_cnt  <= wait_cnt + 4'd1;
            out_valid <= one_hot(s);
            out       <= data_bit ? one_hot(s) : 8'h00;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 8'h00;
          out       <= 8'h00;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.s         = s;
  assign bus.out       = out;
  assign bus.out_valid = out_valid;
  assign bus.drop      = drop;
  assign bus.drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_demux_scheduler.sv
// Directed bench for demux_scheduler: round-robin order, sparse masks,
// empty mask, ack timeout and boundary, drop counter saturation and
// reset during a transfer.
module tb_demux_scheduler;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  demux_scheduler_if bus();

  demux_scheduler #(.TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net against a hung run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One accepted bit followed by an immediate ack (two cycles per bit).
  task automatic xfer(input logic d, input logic [2:0] es, input string tag);
    logic [7:0] oh;
    oh = 8'h01 << es;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.out_ack  = 8'h00;
    #1 check_val({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check_val({tag, "_s"}, 32'(bus.s), 32'(es));
    check_val({tag, "_vld"}, 32'(bus.out_valid), 32'(oh));
    check_val({tag, "_out"}, 32'(bus.out), d ? 32'(oh) : 32'd0);
    check_val({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    bus.out_ack  = oh;
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
    bus.en_mask  = 8'h00;
    bus.out_ack  = 8'h00;

    // Reset state.
    repeat (2) @(negedge clk);
    check_val("rst_s", 32'(bus.s), 32'd0);
    check_val("rst_vld", 32'(bus.out_valid), 32'd0);
    check_val("rst_out", 32'(bus.out), 32'd0);
    check_val("rst_drop", 32'(bus.drop), 32'd0);
    check_val("rst_cnt", 32'(bus.drop_cnt), 32'd0);
    check_val("rst_rdy", 32'(bus.in_ready), 32'd0);
    rst_n       = 1'b1;
    bus.en_mask = 8'hFF;

    // Full mask, nine back-to-back bits: s walks 0..7 then wraps to 0.
    for (int i = 0; i < 9; i++) begin
      xfer((i % 3) != 1, 3'(i % 8), "rr");
    end

    // Sparse mask 1010_0100 starting from ptr 1: 2,5,7,2.
    @(negedge clk);
    bus.out_ack = 8'h00;
    check_val("rr_idle", 32'(bus.out_valid), 32'd0);
    bus.en_mask = 8'hA4;
    xfer(1'b1, 3'd2, "sp0");
    xfer(1'b1, 3'd5, "sp1");
    xfer(1'b1, 3'd7, "sp2");
    xfer(1'b1, 3'd2, "sp3");

    // Empty mask blocks acceptance; s holds in IDLE.
    @(negedge clk);
    bus.out_ack  = 8'h00;
    bus.en_mask  = 8'h00;
    bus.in_valid = 1'b1;
    bus.in_data  = 1'b1;
    #1 check_val("nomask_rdy", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check_val("nomask_vld", 32'(bus.out_valid), 32'd0);
    check_val("nomask_hold", 32'(bus.s), 32'd2);
    bus.in_valid = 1'b0;
    bus.en_mask  = 8'h08;
    #1 check_val("mask8_rdy", 32'(bus.in_ready), 32'd1);
    xfer(1'b1, 3'd3, "mask8");

    // Timeout with no ack: s = 4, valid for exactly 15 cycles, then drop.
    @(negedge clk);
    bus.out_ack  = 8'h00;
    bus.en_mask  = 8'hFF;
    bus.in_valid = 1'b1;
    bus.in_data  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_val("to_s", 32'(bus.s), 32'd4);
    check_val("to_vld0", 32'(bus.out_valid), 32'h10);
    for (int k = 1; k < 15; k++) begin
      @(negedge clk);
      check_val("to_vld", 32'(bus.out_valid), 32'h10);
      check_val("to_nodrop", 32'(bus.drop), 32'd0);
    end
    @(negedge clk);
    check_val("to_end_vld", 32'(bus.out_valid), 32'd0);
    check_val("to_drop", 32'(bus.drop), 32'd1);
    check_val("to_cnt", 32'(bus.drop_cnt), 32'd1);
    @(negedge clk);
    check_val("to_pulse", 32'(bus.drop), 32'd0);

    // Next grant from s+1 = 5; mask cleared and foreign acks mid-transfer,
    // then the own ack lands on the timeout boundary cycle: success.
    bus.in_valid = 1'b1;
    bus.in_data  = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_val("bd_s", 32'(bus.s), 32'd5);
    check_val("bd_out", 32'(bus.out), 32'd0);
    bus.en_mask = 8'h00;
    bus.out_ack = 8'hDF;
    for (int k = 1; k < 14; k++) begin
      @(negedge clk);
      check_val("bd_vld", 32'(bus.out_valid), 32'h20);
      check_val("bd_s_hold", 32'(bus.s), 32'd5);
    end
    @(negedge clk);
    check_val("bd_last_vld", 32'(bus.out_valid), 32'h20);
    bus.out_ack = 8'h20;
    @(negedge clk);
    check_val("bd_done_vld", 32'(bus.out_valid), 32'd0);
    check_val("bd_nodrop", 32'(bus.drop), 32'd0);
    check_val("bd_cnt", 32'(bus.drop_cnt), 32'd1);
    bus.out_ack = 8'h00;
    bus.en_mask = 8'hFF;

    // 256 more timeouts: counter reaches 255 and saturates there.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (15) @(negedge clk);
      check_val("sat_drop", 32'(bus.drop), 32'd1);
      if (i == 253) begin
        check_val("sat_255", 32'(bus.drop_cnt), 32'd255);
      end
    end
    check_val("sat_hold", 32'(bus.drop_cnt), 32'd255);

    // Reset in the middle of a transfer at s = 4.
    @(negedge clk);
    bus.en_mask  = 8'h10;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_val("mr_s", 32'(bus.s), 32'd4);
    check_val("mr_vld", 32'(bus.out_valid), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check_val("mr_out", 32'(bus.out), 32'd0);
    check_val("mr_vld0", 32'(bus.out_valid), 32'd0);
    check_val("mr_s0", 32'(bus.s), 32'd0);
    check_val("mr_drop", 32'(bus.drop), 32'd0);
    check_val("mr_cnt", 32'(bus.drop_cnt), 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    bus.en_mask = 8'hFF;
    repeat (2) begin
      @(negedge clk);
      check_val("mr_nodrop", 32'(bus.drop), 32'd0);
      check_val("mr_cnt_hold", 32'(bus.drop_cnt), 32'd0);
    end
    xfer(1'b1, 3'd0, "mr_next");
    @(negedge clk);
    bus.out_ack = 8'h00;
    check_val("final_idle", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
